// File: rtl/jk_excite_gen_if.sv
// Target-word handshake bundle for jk_excite_gen.
// Master offers a word; slave accepts it when ready.
interface jk_excite_gen_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (
    output tgt_valid,
    output tgt_data,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_data,
    output tgt_ready
  );
endinterface

// File: rtl/jk_excite_gen.sv
// JK bank write-side excitation generator with mirror and Q check.
// Optional macro JK_TOGGLE_PREF_EN: changing bits use toggle code J=K=1.
module jk_excite_gen #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  jk_excite_gen_if.slave   tgt,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             drv_valid,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] mirror,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK
  } state_t;

  state_t           st;
  state_t           nxt;
  logic             ready;
  logic             accept;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] j_nx;
  logic [WIDTH-1:0] k_nx;

`ifdef JK_TOGGLE_PREF_EN
  assign j_nx = mirror ^ tgt.tgt_data;
  assign k_nx = mirror ^ tgt.tgt_data;
`else
  assign j_nx = ~mirror & tgt.tgt_data;
  assign k_nx = mirror & ~tgt.tgt_data;
`endif

  assign tgt.tgt_ready = ready;

  always_ff @(posedge CLK) begin
    if (!RESET) st <= S_IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt    = st;
    ready  = 1'b0;
    busy   = 1'b1;
    accept = 1'b0;
    unique case (st)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (tgt.tgt_valid) begin
          accept = 1'b1;
          nxt    = S_DRIVE;
        end
      end
      S_DRIVE:  nxt = S_SETTLE;
      S_SETTLE: if (cnt == 4'd1) nxt = S_CHECK;
      S_CHECK:  nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // J/K are registered at accept so they are live for the DRIVE cycle only
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      mirror    <= '0;
      J         <= '0;
      K         <= '0;
      drv_valid <= 1'b0;
      err       <= 1'b0;
      cnt       <= 4'd0;
      tgt_q     <= '0;
    end else begin
      J         <= '0;
      K         <= '0;
      drv_valid <= 1'b0;
      if (accept) begin
        tgt_q     <= tgt.tgt_data;
        J         <= j_nx;
        K         <= k_nx;
        drv_valid <= 1'b1;
      end
      if (st == S_DRIVE) begin
        mirror <= tgt_q;
        cnt    <= 4'(SETTLE);
      end else if (st == S_SETTLE) begin
        cnt <= cnt - 4'd1;
      end
      if (st == S_CHECK && q_fb != mirror)
        err <= 1'b1;
    end
  end

endmodule

// File: doc/jk_excite_gen.md
Name: jk_excite_gen

Overview:
Drives a downstream bank of WIDTH JK flip-flops, the write side of the JK register interface. It accepts target words over a valid/ready handshake and computes per-bit J/K excitation from a mirrored copy of the register's current state. It issues one excitation cycle, then waits a settle window and checks the register's fed-back Q against the mirror. It sits between control logic and any JK-based state register.

Parameters:
WIDTH, 4, number of JK flip-flops driven (1..32)
SETTLE, 2, idle cycles after an excitation pulse before Q feedback is compared (1..15)

Ports:
CLK  input  1  system clock, all logic rising-edge
RESET  input  1  synchronous active-low reset (0 = reset, sampled on CLK rise)
tgt_valid  input  1  target word offered
tgt_ready  output  1  block can accept target word
tgt_data  input  WIDTH  requested next register value
J  output  WIDTH  J excitation vector to JK bank
K  output  WIDTH  K excitation vector to JK bank
drv_valid  output  1  J/K are live this cycle (one-cycle pulse)
q_fb  input  WIDTH  Q outputs of the JK bank
mirror  output  WIDTH  block's model of current register value
busy  output  1  high in any state except IDLE
err  output  1  sticky mismatch flag

Behaviour:
- Interface as decided: one clock CLK; RESET is synchronous and active-low.
- Reset (RESET=0 at a CLK edge): state=IDLE, mirror=0, J=0, K=0, drv_valid=0, err=0, settle counter=0. Reset mid-operation aborts the current transfer immediately. A pulse in flight is dropped and no compare occurs.
- During reset and in non-DRIVE states, J=K=0, which is a hold code, so the JK bank keeps its value.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - tgt_ready=1.
  - On tgt_valid&&tgt_ready, latch tgt_data into tgt_q and go to DRIVE.
- DRIVE (exactly 1 cycle):
  - drv_valid=1.
  - Per bit i, from (mirror[i], tgt_q[i]):
    - 0->0: J=0, K=0
    - 0->1: J=1, K=0
    - 1->0: J=0, K=1
    - 1->1: J=0, K=0
  - J/K are registered outputs valid during the DRIVE cycle. The JK bank captures them at the end of that cycle.
  - Next state is SETTLE. mirror<=tgt_q at the same edge.
- SETTLE:
  - Count SETTLE cycles with a counter loaded at the DRIVE exit, then go to CHECK.
  - tgt_ready=0.
- CHECK (1 cycle):
  - If q_fb!=mirror, set err=1. err is sticky and cleared only by reset.
  - The mirror is not overwritten by q_fb.
  - Return to IDLE.
- Latency: handshake accept edge -> DRIVE cycle next -> tgt_ready high again SETTLE+2 cycles after DRIVE. Throughput is one word per SETTLE+3 cycles.
- tgt_ready depends only on state (IDLE), never combinationally on tgt_valid.
- A target equal to mirror still runs the full sequence with an all-hold pulse (J=K=0) and drv_valid=1.
- tgt_valid held high across returns to IDLE: each IDLE cycle with valid accepts a new word. There is no back-to-back accept without IDLE.
- busy=1 in DRIVE, SETTLE and CHECK.
- X on tgt_data outside an accept cycle must not affect state.

Optional Feature:
Macro JK_TOGGLE_PREF_EN.
- Defined: changing bits (0->1 and 1->0) use the toggle code J=1, K=1. Non-changing bits still use J=K=0. The result is identical for a correct JK bank and exercises the toggle path.
- Undefined: the set/reset codes in the table above apply, and J&K is always 0. The bench asserts J&K==0 on every cycle only when the macro is undefined.

Test Plan:
- Reset then idle, WIDTH=4: hold RESET=0 for 2 cycles, then release -> mirror=0, J=K=0, tgt_ready=1, err=0, busy=0.
- Single write: tgt_data=4'b1010 from mirror 0 -> DRIVE cycle gives J=4'b1010, K=4'b0000, drv_valid=1. The bank model yields q_fb=1010. err stays 0. tgt_ready returns SETTLE+2=4 cycles after DRIVE.
- Mixed write: mirror=1010, target 0110 -> J=4'b0100, K=4'b1000 (or J=K=4'b1100 with JK_TOGGLE_PREF_EN). Final mirror=0110.
- Mismatch detection: the bank model forces q_fb bit0 stuck at 0 and target 0001 is written -> err=1 in the CHECK cycle. err stays 1 through later correct writes until reset.
- Reset mid-transfer: assert RESET=0 during SETTLE -> next cycle state is IDLE, mirror=0, no err update, no further drv_valid.
- Back-to-back valid: tgt_valid held high with targets 0011 then 0011 -> two accepts spaced SETTLE+3 cycles apart. The second DRIVE shows J=K=0 with drv_valid=1.
